// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - N_IN-lane bitwise logic unit with 2-entry output FIFO; optional LOGIC_GATE_UNIT_STATUS_EN
module logic_gate_unit #(
    parameter int W    = 4,
    parameter int N_IN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_IN*W-1:0]   in_data,
    input  logic [2:0]          op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
`ifdef LOGIC_GATE_UNIT_STATUS_EN
    output logic                out_zero,
    output logic                out_ones,
`endif
    output logic [2:0]          out_op
);

    logic [W-1:0] red_and;
    logic [W-1:0] red_or;
    logic [W-1:0] red_xor;
    logic [W-1:0] result;

    logic [W-1:0] mem_data [2];
    logic [2:0]   mem_op   [2];
`ifdef LOGIC_GATE_UNIT_STATUS_EN
    logic         mem_zero [2];
    logic         mem_ones [2];
`endif
    logic         wptr;
    logic         rptr;
    logic [1:0]   count;
    logic         live;
    logic         push;
    logic         pop;

    // Bitwise reduction of all lanes, then select the requested operation
    always_comb begin
        red_and = in_data[W-1:0];
        red_or  = in_data[W-1:0];
        red_xor = in_data[W-1:0];
        for (int i = 1; i < N_IN; i++) begin
            red_and = red_and & in_data[i*W +: W];
            red_or  = red_or  | in_data[i*W +: W];
            red_xor = red_xor ^ in_data[i*W +: W];
        end
        case (op)
            3'd0:    result = red_and;
            3'd1:    result = red_or;
            3'd2:    result = red_xor;
            3'd3:    result = ~red_and;
            3'd4:    result = ~red_or;
            3'd5:    result = ~red_xor;
            3'd6:    result = in_data[W-1:0];
            default: result = ~in_data[W-1:0];
        endcase
    end

    // in_ready depends only on registered state, never on out_ready
    assign in_ready  = live && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = out_valid ? mem_data[rptr] : '0;
    assign out_op    = out_valid ? mem_op[rptr]   : 3'd0;
`ifdef LOGIC_GATE_UNIT_STATUS_EN
    assign out_zero  = out_valid && mem_zero[rptr];
    assign out_ones  = out_valid && mem_ones[rptr];
`endif

    // FIFO storage, pointers and occupancy; live marks the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_op[i]   <= 3'd0;
`ifdef LOGIC_GATE_UNIT_STATUS_EN
                mem_zero[i] <= 1'b0;
                mem_ones[i] <= 1'b0;
`endif
            end
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
            live  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (push) begin
                mem_data[wptr] <= result;
                mem_op[wptr]   <= op;
`ifdef LOGIC_GATE_UNIT_STATUS_EN
                mem_zero[wptr] <= (result == '0);
                mem_ones[wptr] <= (result == '1);
`endif
                wptr <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_gate_unit.sv
// tb/tb_logic_gate_unit.sv - randomized self-checking bench for logic_gate_unit
module tb_logic_gate_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [2:0]  out_op;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [31:0] w_in_data;
    logic [2:0]  w_op;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [7:0]  w_out_data;
    logic [2:0]  w_out_op;

`ifdef LOGIC_GATE_UNIT_STATUS_EN
    logic        out_zero;
    logic        out_ones;
    logic        w_out_zero;
    logic        w_out_ones;
`endif

    int checks;
    int errors;

    logic [6:0] mq[$];
    logic       mlive;

    logic [3:0] truth_exp [8];

    logic_gate_unit #(.W(4), .N_IN(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef LOGIC_GATE_UNIT_STATUS_EN
        .out_zero  (out_zero),
        .out_ones  (out_ones),
`endif
        .out_op    (out_op)
    );

    logic_gate_unit #(.W(8), .N_IN(4)) dut_wide (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_data),
        .op        (w_op),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_data  (w_out_data),
`ifdef LOGIC_GATE_UNIT_STATUS_EN
        .out_zero  (w_out_zero),
        .out_ones  (w_out_ones),
`endif
        .out_op    (w_out_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-bit population count across lanes decides every operation
    function automatic logic [7:0] ref_calc(input logic [31:0] d, input logic [2:0] o,
                                            input int w, input int n);
        logic [7:0] r;
        int ones;
        logic all1, any1, odd1, l0;
        r = 8'd0;
        for (int b = 0; b < w; b++) begin
            ones = 0;
            for (int l = 0; l < n; l++) ones += int'(d[l*w + b]);
            all1 = (ones == n);
            any1 = (ones > 0);
            odd1 = (ones % 2) == 1;
            l0   = d[b];
            case (o)
                3'd0: r[b] = all1;
                3'd1: r[b] = any1;
                3'd2: r[b] = odd1;
                3'd3: r[b] = !all1;
                3'd4: r[b] = !any1;
                3'd5: r[b] = !odd1;
                3'd6: r[b] = l0;
                default: r[b] = !l0;
            endcase
        end
        return r;
    endfunction

    // Expected {in_ready, out_valid, out_op, out_data} from the queue model
    function automatic logic [8:0] exp_vec();
        logic rdy, vld;
        logic [6:0] head;
        rdy  = mlive && (mq.size() < 2);
        vld  = (mq.size() != 0);
        head = vld ? mq[0] : 7'd0;
        return {rdy, vld, head[2:0], head[6:3]};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {in_ready, out_valid, out_op, out_data};
    endfunction

    // One clock of the narrow DUT with the model stepped alongside
    task automatic tick();
        logic push, pop;
        logic [7:0] r;
        push = in_valid && mlive && (mq.size() < 2);
        pop  = (mq.size() != 0) && out_ready;
        r    = ref_calc({24'd0, in_data}, op, 4, 2);
        @(posedge clk);
        if (pop) mq.delete(0);
        if (push) mq.push_back({r[3:0], op});
        mlive = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (dut_vec() !== 9'd0) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", dut_vec(), 9'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b exp 0", in_ready);
        end
        @(negedge clk);
        tick();
        checks++;
        if (dut_vec() !== exp_vec() || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %h exp %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_truth_table();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'b0101_0011;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || out_data !== truth_exp[i] ||
                out_op !== 3'(i) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL truth_op%0d got %h exp data %b vec %h", i, dut_vec(), truth_exp[i], exp_vec());
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== exp_vec() || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL truth_drain got %h exp %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] got[$];
        logic pushing;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'b0101_0011;
        for (int i = 0; i < 3; i++) begin
            op = 3'(i);
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || out_data !== 4'b0001 ||
                (i > 0 && in_ready !== 1'b0)) begin
                errors++;
                $display("FAIL fill_%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (got.size() >= 3) break;
            if (out_valid) got.push_back(out_data);
            pushing = in_valid && (mq.size() < 2);
            tick();
            if (pushing) in_valid = 1'b0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain_%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (got.size() != 3 || got[0] !== 4'b0001 || got[1] !== 4'b0111 || got[2] !== 4'b0110) begin
            errors++;
            $display("FAIL drain_order got %0d items exp 0001 0111 0110", got.size());
        end
        for (int i = 0; i < 4 && mq.size() != 0; i++) tick();
    endtask

    task automatic test_back_to_back();
        int pushes, pops;
        pushes = 0;
        pops   = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_data = 8'($urandom);
            op      = 3'($urandom);
            if (out_valid) pops++;
            pushes++;
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || in_ready !== 1'b1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (pushes - pops != 1 || mq.size() != 1) begin
            errors++;
            $display("FAIL stream_balance got %0d held exp 1", mq.size());
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom % 3) != 0;
            in_data   = 8'($urandom);
            op        = 3'($urandom);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        op        = 3'd1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (dut_vec() !== exp_vec() || mq.size() != 2) begin
            errors++;
            $display("FAIL pre_reset_full got %h exp %h", dut_vec(), exp_vec());
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        mlive = 1'b0;
        checks++;
        if (dut_vec() !== 9'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", dut_vec(), 9'd0);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        op        = 3'd4;
        tick();
        checks++;
        if (dut_vec() !== exp_vec() || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got %h exp %h", dut_vec(), exp_vec());
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (dut_vec() !== exp_vec() || out_data !== 4'b1111 || out_op !== 3'd4) begin
            errors++;
            $display("FAIL post_reset_first got %h exp %h", dut_vec(), exp_vec());
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_only_%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

`ifdef LOGIC_GATE_UNIT_STATUS_EN
    task automatic test_status();
        logic [7:0] sd [3];
        logic [2:0] so [3];
        logic [1:0] ef;
        sd[0] = 8'b0101_0011; so[0] = 3'd0;
        sd[1] = 8'b0000_0000; so[1] = 3'd4;
        sd[2] = 8'b0011_1100; so[2] = 3'd0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) in_valid = 1'b0;
            else begin
                in_data = sd[i];
                op      = so[i];
            end
            tick();
            ef = (mq.size() == 0) ? 2'b00 : {mq[0][6:3] == 4'h0, mq[0][6:3] == 4'hF};
            checks++;
            if ({out_zero, out_ones} !== ef || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL status_%0d got %b exp %b", i, {out_zero, out_ones}, ef);
            end
        end
    endtask
`endif

    task automatic test_wide();
        logic [7:0] wexp [4];
        logic [2:0] wops [4];
        logic [7:0] r;
        wops[0] = 3'd0; wexp[0] = 8'h00;
        wops[1] = 3'd1; wexp[1] = 8'hFF;
        wops[2] = 3'd2; wexp[2] = 8'hCD;
        wops[3] = 3'd4; wexp[3] = 8'h00;
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_in_data   = {8'h01, 8'h3C, 8'h0F, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            w_op = wops[i];
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (w_out_valid !== 1'b1 || w_out_data !== wexp[i] || w_out_op !== wops[i]) begin
                errors++;
                $display("FAIL wide_op%0d got %h exp %h", wops[i], w_out_data, wexp[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            w_in_data = $urandom;
            w_op      = 3'($urandom);
            r = ref_calc(w_in_data, w_op, 8, 4);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (w_out_valid !== 1'b1 || w_out_data !== r || w_out_op !== w_op) begin
                errors++;
                $display("FAIL wide_rand_%0d got %h exp %h", i, w_out_data, r);
            end
        end
        w_in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mlive  = 1'b0;
        truth_exp[0] = 4'b0001; truth_exp[1] = 4'b0111;
        truth_exp[2] = 4'b0110; truth_exp[3] = 4'b1110;
        truth_exp[4] = 4'b1000; truth_exp[5] = 4'b1001;
        truth_exp[6] = 4'b0011; truth_exp[7] = 4'b1100;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        op          = 3'd0;
        out_ready   = 1'b0;
        w_in_valid  = 1'b0;
        w_in_data   = 32'd0;
        w_op        = 3'd0;
        w_out_ready = 1'b0;

        test_reset();
        test_truth_table();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midstream();
`ifdef LOGIC_GATE_UNIT_STATUS_EN
        test_status();
`endif
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_wide();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
- Parametrised, pipelined successor to the single 2-input combinational gate.
- Applies one of eight selectable bitwise logic operations across N_IN operand lanes, each W bits wide.
- Results pass through a 2-entry result buffer with a valid/ready handshake on both sides.
- Used as a reusable logic stage in lab datapaths. Sits between an operand producer and any back-pressuring consumer.

Parameters:
- W, 4, bit width of each operand lane and of the result (W ≥ 1).
- N_IN, 2, number of operand lanes reduced together (N_IN ≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set present on in_data/op.
- in_ready  output  1  block can accept an operand set this cycle.
- in_data  input  N_IN*W  packed lanes; lane i occupies bits [i*W +: W].
- op  input  3  operation select, sampled together with in_data.
- out_valid  output  1  result at head of buffer is valid.
- out_ready  input  1  consumer takes the head result this cycle.
- out_data  output  W  head result.
- out_op  output  3  op code that produced out_data.

Behaviour:
- Reset: clk single clock; rst_n asynchronous assert, active low; release synchronous to clk.
  - While rst_n=0: buffer count=0, out_valid=0, in_ready=0, out_data=0, out_op=0.
  - Buffer contents cleared to 0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- Op codes, bitwise reduction across all N_IN lanes:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 PASS (lane 0), 7 NOT (lane 0).
  - NAND/NOR/XNOR are the bitwise complement of AND/OR/XOR.
- Accept: on a rising edge where in_valid && in_ready.
  - Result is computed combinationally from in_data/op in that cycle.
  - {result, op} is written to the tail entry.
- Buffer: 2-entry FIFO, count 0..2.
  - in_ready = rst released && count<2. It is registered state only, with no combinational path from out_ready.
  - out_valid = count≠0. out_data/out_op always show the head entry; they hold 0 when count=0.
- Latency: a result accepted at edge k is visible with out_valid=1 immediately after edge k (1 cycle), provided the buffer was empty.
- Pop: on an edge where out_valid && out_ready, the head entry is removed.
- Simultaneous push and pop:
  - count unchanged.
  - FIFO order preserved.
  - At count=1, the new entry becomes head after the pop.
- Full (count=2): in_ready=0; in_valid is ignored. A pop that cycle leaves count=1, and in_ready returns to 1 the next cycle.
- Empty (count=0): out_ready is ignored; no underflow.
- Pointer wrap: read/write pointers are 1 bit each and wrap modulo 2.
- Holding rules:
  - out_data/out_op are stable while out_valid=1 and out_ready=0.
  - in_data/op changes while in_ready=0 have no effect.
- Reset mid-operation: all entries are discarded at once; no partial result appears after reset.

Optional Feature:
- Macro: LOGIC_GATE_UNIT_STATUS_EN.
- When defined:
  - Adds output out_zero (1 bit), high when the head out_data is all 0s.
  - Adds output out_ones (1 bit), high when the head out_data is all 1s.
  - Both flags are stored per entry alongside the result and qualified by out_valid (0 when count=0).
  - Both reset to 0.
- When undefined: these ports and their storage do not exist. All other behaviour is identical.

Test Plan (W=4, N_IN=2 unless noted):
- Truth-table sweep, out_ready=1:
  - Lanes a=4'b0011, b=4'b0101, op 0..7 one per cycle.
  - Expected out_data in order: 0001, 0111, 0110, 1110, 1000, 1001, 0011, 1100.
  - Each result appears 1 cycle after acceptance; out_op matches each result.
- Back-pressure fill:
  - out_ready=0; offer three sets (AND, OR, XOR of 0011/0101).
  - Expected: first two accepted; in_ready=0 after the second; third held off; out_data stays 0001.
  - Raise out_ready → 0001, 0111, 0110 delivered in order.
- Simultaneous push/pop at count=1: count stays 1 and in_ready stays 1 across 10 cycles of continuous streaming. No result is lost or duplicated.
- Reset mid-stream:
  - Assert rst_n=0 with count=2, asynchronously between edges.
  - Expected: out_valid, in_ready, out_data drop to 0 at once.
  - After release, the first new result (NOR 0000,0000 → 1111) is the only output.
- Wide config W=8, N_IN=4, lanes FF, 0F, 3C, 01:
  - AND → 00; OR → FF; XOR → CD; NOR → 00.
- With LOGIC_GATE_UNIT_STATUS_EN:
  - AND 0011,0101 → out_zero=0, out_ones=0.
  - NOR 0000,0000 → out_ones=1.
  - AND 1100,0011 → out_zero=1.
